// File: rtl/control_pkg.sv
// Shared types and constants for the restoring-divider sequencing controller.
package control_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ITER  = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] SUBU_FUNCT     = 6'b100011;
  localparam logic [5:0] NOP_FUNCT      = 6'b000000;
  localparam int         ITER_N_DEFAULT = 32;
  localparam int         CNT_W          = 6;

endpackage

// File: rtl/control_iter_counter.sv
// Iteration counter: synchronous clear (priority over enable), enable, and a
// terminal-count flag raised while cnt equals tc_val.
module control_iter_counter
  import control_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/control.sv
// Sequencing FSM for the iterative 32-bit restoring divider datapath.
// Optional iter_cnt debug output is enabled by defining CONTROL_ITER_CNT_EN.
//
// state | meaning
// IDLE  | waiting for Run, all strobes low
// INIT  | load operands and initial left shift
// ITER  | subtract/shift iterations, write gated by ~MSB
// FINAL | right-shift correction of the remainder half
// DONE  | result valid, held while Run stays high
module control
  import control_pkg::*;
#(
  parameter int ITER_N = ITER_N_DEFAULT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       MSB,
  output logic       W_ctrl,
  output logic [5:0] SUBU_ctrl,
  output logic       SRL_ctrl,
  output logic       SLL_ctrl,
`ifdef CONTROL_ITER_CNT_EN
  output logic [5:0] iter_cnt,
`endif
  output logic       Ready
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(ITER_N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  // Counter is held at zero outside ITER, which also covers the clear in INIT.
  control_iter_counter u_iter_counter (
    .clk    (clk),
    .rst_n  (Reset),
    .clr    (state != ITER),
    .en     (state == ITER),
    .tc_val (TC_VAL),
    .cnt    (cnt),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Run) state_nxt = INIT;
      INIT:    state_nxt = ITER;
      ITER:    if (cnt_tc) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    W_ctrl    = 1'b0;
    SUBU_ctrl = NOP_FUNCT;
    SRL_ctrl  = 1'b0;
    SLL_ctrl  = 1'b0;
    Ready     = 1'b0;
    case (state)
      INIT: begin
        W_ctrl   = 1'b1;
        SLL_ctrl = 1'b1;
      end
      ITER: begin
        // Only write back a non-negative partial remainder.
        W_ctrl    = ~MSB;
        SUBU_ctrl = SUBU_FUNCT;
        SLL_ctrl  = 1'b1;
      end
      FINAL: begin
        W_ctrl   = 1'b1;
        SRL_ctrl = 1'b1;
      end
      DONE:    Ready = 1'b1;
      default: ;
    endcase
  end

`ifdef CONTROL_ITER_CNT_EN
  // cnt has already advanced to ITER_N by the FINAL cycle, so gate it.
  assign iter_cnt = (state == ITER) ? cnt : '0;
`else
  logic cnt_unused;
  assign cnt_unused = ^cnt;
`endif

endmodule

// File: tb/tb_control.sv
// Randomized bench for control; reference model tracks the cycle position
// within an operation rather than FSM states.
module tb_control;
  import control_pkg::*;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       MSB;
  logic       W_ctrl;
  logic [5:0] SUBU_ctrl;
  logic       SRL_ctrl;
  logic       SLL_ctrl;
  logic       Ready;
`ifdef CONTROL_ITER_CNT_EN
  logic [5:0] iter_cnt;
`endif

  always #5 clk = ~clk;

  control #(.ITER_N(N)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Run       (Run),
    .MSB       (MSB),
    .W_ctrl    (W_ctrl),
    .SUBU_ctrl (SUBU_ctrl),
    .SRL_ctrl  (SRL_ctrl),
    .SLL_ctrl  (SLL_ctrl),
`ifdef CONTROL_ITER_CNT_EN
    .iter_cnt  (iter_cnt),
`endif
    .Ready     (Ready)
  );

  int vectors     = 0;
  int miscompares = 0;
  // -1 idle, 0 load cycle, 1..N iterations, N+1 correction, N+2 done
  int pos         = -1;
  int iter_seen   = 0;
  bit toggle_msb  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       in_iter;
    logic       exp_w;
    logic [5:0] exp_subu;
    in_iter  = (pos >= 1) && (pos <= N);
    exp_w    = (pos == 0) || (pos == N + 1) || (in_iter && !MSB);
    exp_subu = in_iter ? 6'b100011 : 6'b000000;
    check("W_ctrl",    32'(W_ctrl),    32'(exp_w));
    check("SUBU_ctrl", 32'(SUBU_ctrl), 32'(exp_subu));
    check("SLL_ctrl",  32'(SLL_ctrl),  32'((pos >= 0) && (pos <= N)));
    check("SRL_ctrl",  32'(SRL_ctrl),  32'(pos == N + 1));
    check("Ready",     32'(Ready),     32'(pos == N + 2));
    check("shift_excl", 32'(SLL_ctrl & SRL_ctrl), 32'(0));
`ifdef CONTROL_ITER_CNT_EN
    check("iter_cnt",  32'(iter_cnt),  in_iter ? 32'(pos - 1) : 32'(0));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!Reset)          pos = -1;
    else if (pos < 0)    pos = Run ? 0 : -1;
    else if (pos <= N+1) pos = pos + 1;
    else if (!Run)       pos = -1;
    @(negedge clk);
    if (SUBU_ctrl == 6'b100011) iter_seen++;
    check_outputs();
    MSB = toggle_msb ? ~MSB : 1'($urandom_range(0, 1));
  endtask

  task automatic async_reset();
    Reset = 1'b0;
    pos   = -1;
    #1;
    check_outputs();
  endtask

  task automatic measure_latency(input string tag);
    int n;
    n = 0;
    iter_seen = 0;
    do begin
      cycle();
      n++;
    end while (!Ready && n < 100);
    check(tag, 32'(n - 1), 32'(N + 2));
    check("iter_cycles", 32'(iter_seen), 32'(N));
  endtask

  initial begin
    int k;
    Reset = 1'b0;
    Run   = 1'b1;
    MSB   = 1'b0;
    #1;
    check_outputs();
    cycle();
    cycle();

    // Full run with Run held and MSB alternating during iterations
    Reset      = 1'b1;
    toggle_msb = 1'b1;
    measure_latency("latency_first");
    for (int i = 0; i < 3; i++) cycle();
    toggle_msb = 1'b0;

    // Restart from DONE through a one-cycle Run drop
    Run = 1'b0;
    cycle();
    check("ready_fell", 32'(Ready), 32'(0));
    Run = 1'b1;
    measure_latency("latency_restart");

    // Abort at iteration 10 with an asynchronous reset
    Run = 1'b0;
    cycle();
    Run = 1'b1;
    k = 0;
    while (pos != 11 && k < 40) begin
      cycle();
      k++;
    end
    MSB = 1'b0;
    #1;
    check("in_iter_before_reset", 32'(SUBU_ctrl), 32'(SUBU_FUNCT));
    check("w_before_reset", 32'(W_ctrl), 32'(1));
    async_reset();
    cycle();
    Reset = 1'b1;
    measure_latency("latency_after_abort");

    // Random Run/MSB traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      Run = ($urandom_range(0, 3) != 0);
      if (!Reset) Reset = 1'b1;
      else if ($urandom_range(0, 49) == 0) async_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
